ram_reader: RTL and testbench
=============================

Name: ram_reader

Overview:
- Single-clock SDRAM read engine. It is the read-side counterpart of the SD-command write path, which only pushes single words into SDRAM.
- Accepts a (start address, word count) command and issues sequential single-word reads to the SDRAM controller using the toggle req/ack handshake.
- Buffers returned words in a small FIFO and streams them out on a valid/ready port, with a last-word flag.
- Sits between the SDRAM controller and the readback / verify / CRC logic in the controller clock domain.

Parameters:
- ADDR_BITS, 24: SDRAM word address width; must be greater than 16.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  controller clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  read command offered.
- cmd_ready  out  1  block can accept a command.
- cmd_addr  in  ADDR_BITS  first word address.
- cmd_len  in  16  number of words to read; 0 is legal.
- ram_req  out  1  toggle-request to SDRAM controller.
- ram_ack  in  1  controller completion toggle; request is complete when ram_ack equals ram_req.
- ram_we  out  1  always 0; this block only reads.
- ram_address  out  ADDR_BITS  read address; held stable from the req toggle until completion.
- ram_data_read  in  16  read data; valid in the cycle ram_ack becomes equal to ram_req.
- data_valid  out  1  FIFO head valid.
- data_ready  in  1  consumer accepts the head word.
- data  out  16  head word.
- data_last  out  1  head word is the final word of its command.
- busy  out  1  high from command accept until the last word has been popped from the FIFO.

Behaviour:
- Reset values: ram_req 0, ram_we 0, ram_address 0, cmd_ready 0 during reset, data_valid 0, data_last 0, busy 0. FIFO is emptied. State is IDLE.
- Reset contract: the SDRAM controller shares this reset, so ram_ack is 0 after reset. A read in flight at reset is abandoned and its data is never pushed.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid with cmd_len != 0: latch addr into ram_address and len into a remaining counter; busy <= 1; go to ISSUE.
  - On cmd_valid with cmd_len == 0: command is consumed with no reads and no output; stay in IDLE; busy is unchanged.
- ISSUE:
  - When FIFO free slots >= 1, counting the slot reserved for the in-flight read: ram_req <= ~ram_req; go to WAIT.
  - Otherwise stay in ISSUE, which applies backpressure to the SDRAM side.
- WAIT: when ram_ack == ram_req:
  - Push {ram_data_read, last = (remaining == 1)} into the FIFO.
  - ram_address <= ram_address + 1, wrapping modulo 2^ADDR_BITS.
  - remaining <= remaining - 1.
  - If remaining == 1, go to IDLE; otherwise go to ISSUE.
- Only one read is outstanding at a time. Minimum spacing is 2 cycles per word plus controller latency.
- Accept-to-request latency: command accepted at edge N; ISSUE at N+1; ram_req toggles at edge N+1 (if the FIFO has space).
- Completion-to-output latency: a word pushed at edge M shows data_valid = 1 after edge M if the FIFO was empty (FIFO is first-word-fall-through).
- FIFO:
  - Pop when data_valid && data_ready.
  - A simultaneous push and pop when full is impossible by the reservation rule.
  - A simultaneous push and pop when empty is legal; the word appears the next cycle.
- busy clears on the cycle the data_last word is popped while the state is IDLE.
- A new command may be accepted while older words still drain; busy stays 1 in that case.
- cmd_ready is low in ISSUE and WAIT; commands offered then are held by the producer and not lost.
- ram_address is never changed while in WAIT.
- cmd_len = 16'hFFFF reads 65535 words; the remaining counter must not overflow.

Decomposition:
- Package ram_reader_pkg:
  - state enum typedef {IDLE, ISSUE, WAIT}.
  - WORD_BITS = 16.
  - LEN_BITS = 16.
  - FIFO entry struct {data, last}.
- Sub-module word_fifo:
  - Synchronous FWFT FIFO of the entry struct, parameterised by depth.
  - Exposes count, used for the slot reservation.
  - Same clk and reset.

Test Plan:
- Single word: addr 0x000010, len 1. Controller acks after 3 cycles with 0xBEEF -> exactly one output word, 0xBEEF with data_last = 1; ram_req toggled once; busy falls on pop.
- Burst with backpressure: addr 0x000100, len 8, data = address low bits, data_ready held 0 for 20 cycles -> at most FIFO_DEPTH words buffered; ram_req stops toggling; after release, words 0x100..0x107 arrive in order with last only on 0x107.
- Address wrap: ADDR_BITS = 24, addr 0xFFFFFE, len 4 -> ram_address sequence FFFFFE, FFFFFF, 000000, 000001.
- Zero length: len 0 -> no ram_req toggle, no data_valid, busy stays 0, cmd_ready stays 1.
- Back-to-back commands: (0x20, 2) then (0x40, 2) with the consumer always ready -> output 0x20, 0x21(last), 0x40, 0x41(last); second command accepted one cycle after the first reaches IDLE.
- Reset mid-read: reset asserted in WAIT with len 5 after 2 words -> FIFO empty, data_valid 0, ram_req 0, busy 0, cmd_ready 1 one cycle after reset deasserts.

Source files
------------

// File: rtl/ram_reader_pkg.sv
// rtl/ram_reader_pkg.sv - shared types and constants for the SDRAM read engine
package ram_reader_pkg;

    localparam int WORD_BITS = 16;
    localparam int LEN_BITS  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WORD_BITS-1:0] data;
        logic                 last;
    } fifo_entry_t;

endpackage

// File: rtl/ram_reader_if.sv
// rtl/ram_reader_if.sv - command, SDRAM and output-stream signals of the read engine
interface ram_reader_if #(
    parameter int ADDR_BITS = 24
);
    import ram_reader_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;

    logic                 ram_req;
    logic                 ram_ack;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_address;
    logic [WORD_BITS-1:0] ram_data_read;

    logic                 data_valid;
    logic                 data_ready;
    logic [WORD_BITS-1:0] data;
    logic                 data_last;
    logic                 busy;

    // Read engine side
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, ram_ack, ram_data_read, data_ready,
        output cmd_ready, ram_req, ram_we, ram_address, data_valid, data, data_last, busy
    );

    // Command producer / SDRAM controller / consumer side
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, ram_ack, ram_data_read, data_ready,
        input  cmd_ready, ram_req, ram_we, ram_address, data_valid, data, data_last, busy
    );

endinterface

// File: rtl/ram_reader_fifo.sv
// rtl/ram_reader_fifo.sv - first-word-fall-through FIFO of {data, last} entries
module word_fifo
    import ram_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  fifo_entry_t              push_entry_i,
    input  logic                     pop_i,
    output fifo_entry_t              head_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    fifo_entry_t         mem_q [DEPTH];
    logic [PTR_BITS-1:0] rd_ptr_q;
    logic [PTR_BITS-1:0] wr_ptr_q;
    logic [CNT_BITS-1:0] count_q;

    logic do_pop;
    logic do_push;

    // An empty FIFO ignores pops; a full one only takes a push alongside a pop
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CNT_BITS'(DEPTH)) || do_pop);

    // Storage array; contents are don't-care until written, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all entries
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_BITS'(1);
                2'b01:   count_q <= count_q - CNT_BITS'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_reader.sv
// rtl/ram_reader.sv - sequential single-word SDRAM reader with buffered stream output
module ram_reader
    import ram_reader_pkg::*;
#(
    parameter int ADDR_BITS  = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    ram_reader_if.master bus
);

    localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    state_t               state_q,     state_d;
    logic                 ram_req_q,   ram_req_d;
    logic [ADDR_BITS-1:0] address_q,   address_d;
    logic [LEN_BITS-1:0]  remaining_q, remaining_d;
    logic                 busy_q,      busy_d;

    logic                 push;
    fifo_entry_t          push_entry;
    logic                 pop;
    fifo_entry_t          head;
    logic                 head_valid;
    logic [CNT_BITS-1:0]  fifo_count;
    logic                 idle_ready;

    assign idle_ready = (state_q == IDLE);
    assign pop        = head_valid && bus.data_ready;
    assign push_entry = '{data: bus.ram_data_read, last: (remaining_q == LEN_BITS'(1))};

    word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .valid_o      (head_valid),
        .count_o      (fifo_count)
    );

    // Next-state: accept commands, issue one read at a time, collect completions
    always_comb begin
        state_d     = state_q;
        ram_req_d   = ram_req_q;
        address_d   = address_q;
        remaining_d = remaining_q;
        busy_d      = busy_q;
        push        = 1'b0;

        // Drop busy once the final buffered word of the final command leaves
        if (pop && head.last && (fifo_count == CNT_BITS'(1)) && (state_q == IDLE)) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && (bus.cmd_len != '0)) begin
                    address_d   = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // No read is in flight here, so any free slot can be reserved for it
                if (fifo_count < CNT_BITS'(FIFO_DEPTH)) begin
                    ram_req_d = ~ram_req_q;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (bus.ram_ack == ram_req_q) begin
                    push        = 1'b1;
                    address_d   = address_q + ADDR_BITS'(1);
                    remaining_d = remaining_q - LEN_BITS'(1);
                    state_d     = (remaining_q == LEN_BITS'(1)) ? IDLE : ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; an in-flight read is abandoned on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ram_req_q   <= 1'b0;
            address_q   <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_req_q   <= ram_req_d;
            address_q   <= address_d;
            remaining_q <= remaining_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready   = idle_ready && !reset;
    assign bus.ram_req     = ram_req_q;
    assign bus.ram_we      = 1'b0;
    assign bus.ram_address = address_q;
    assign bus.data_valid  = head_valid;
    assign bus.data        = head.data;
    assign bus.data_last   = head_valid && head.last;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ram_reader.sv
// tb/tb_ram_reader.sv - directed self-checking bench for ram_reader
module tb_ram_reader;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    ram_reader_if #(.ADDR_BITS(24)) bus ();

    ram_reader #(
        .ADDR_BITS  (24),
        .FIFO_DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0] req_addr [$];
    logic [15:0] pop_data [$];
    logic        pop_last [$];

    logic        prev_req = 1'b0;
    logic [23:0] held_addr = '0;
    int          lat_cnt = 0;
    int          ack_lat = 3;

    typedef struct {
        logic [23:0] addr;
        logic [15:0] len;
        int          exp_words;
        logic [15:0] exp_first;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] mem_data(input logic [23:0] a);
        return (a == 24'h000010) ? 16'hBEEF : a[15:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SDRAM controller model: completes each toggle request after ack_lat cycles
    always @(negedge clk) begin
        if (reset) begin
            bus.ram_ack       = 1'b0;
            bus.ram_data_read = 16'h0;
            lat_cnt           = 0;
        end else if (bus.ram_req != bus.ram_ack) begin
            lat_cnt++;
            if (lat_cnt >= ack_lat) begin
                bus.ram_ack       = bus.ram_req;
                bus.ram_data_read = mem_data(bus.ram_address);
                lat_cnt           = 0;
            end
        end
    end

    // Observer: logs request toggles and popped words, checks address stability
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 1'b0;
        end else begin
            if (bus.ram_req != prev_req) begin
                req_addr.push_back(bus.ram_address);
                held_addr = bus.ram_address;
                prev_req  = bus.ram_req;
            end else if (bus.ram_req != bus.ram_ack) begin
                check("addr_stable", {8'h0, bus.ram_address}, {8'h0, held_addr});
            end
            check("ram_we", {31'h0, bus.ram_we}, 32'h0);
            if (bus.data_valid && bus.data_ready) begin
                pop_data.push_back(bus.data);
                pop_last.push_back(bus.data_last);
            end
        end
    end

    task automatic clear_logs();
        req_addr.delete();
        pop_data.delete();
        pop_last.delete();
    endtask

    task automatic send_cmd(input logic [23:0] addr, input logic [15:0] len);
        bit found = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        for (int i = 0; i < 500; i++) begin
            if (bus.cmd_ready) begin
                tick();
                found = 1;
                break;
            end
            tick();
        end
        bus.cmd_valid = 1'b0;
        check("cmd_accept", {31'h0, found}, 32'h1);
    endtask

    task automatic wait_done();
        bit done = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!bus.busy && bus.cmd_ready && !bus.data_valid) begin
                done = 1;
                break;
            end
            tick();
        end
        check("done_timeout", {31'h0, done}, 32'h1);
    endtask

    task automatic compare_words(input logic [23:0] addr, input int n, input logic [15:0] first);
        logic [23:0] a;
        check("word_count", pop_data.size(), n);
        check("req_count", req_addr.size(), n);
        for (int i = 0; i < n; i++) begin
            a = addr + 24'(i);
            if (i < req_addr.size()) check("req_addr", {8'h0, req_addr[i]}, {8'h0, a});
            if (i < pop_data.size()) begin
                check("word_data", {16'h0, pop_data[i]}, {16'h0, (i == 0) ? first : a[15:0]});
                check("word_last", {31'h0, pop_last[i]}, {31'h0, (i == n - 1)});
            end
        end
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{addr: 24'h000010, len: 16'd1, exp_words: 1, exp_first: 16'hBEEF};
        vecs[1] = '{addr: 24'hFFFFFE, len: 16'd4, exp_words: 4, exp_first: 16'hFFFE};
        vecs[2] = '{addr: 24'h000000, len: 16'd0, exp_words: 0, exp_first: 16'h0000};
        vecs[3] = '{addr: 24'h000500, len: 16'd3, exp_words: 3, exp_first: 16'h0500};
        vecs[4] = '{addr: 24'h00ABCD, len: 16'd2, exp_words: 2, exp_first: 16'hABCD};

        bus.cmd_valid  = 1'b0;
        bus.cmd_addr   = '0;
        bus.cmd_len    = '0;
        bus.data_ready = 1'b1;

        // Reset values
        reset = 1'b1;
        repeat (3) tick();
        check("rst_ram_req", {31'h0, bus.ram_req}, 32'h0);
        check("rst_ram_we", {31'h0, bus.ram_we}, 32'h0);
        check("rst_ram_address", {8'h0, bus.ram_address}, 32'h0);
        check("rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h0);
        check("rst_data_valid", {31'h0, bus.data_valid}, 32'h0);
        check("rst_data_last", {31'h0, bus.data_last}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);

        // Table of single commands with an always-ready consumer
        foreach (vecs[k]) begin
            clear_logs();
            send_cmd(vecs[k].addr, vecs[k].len);
            check("busy_after_accept", {31'h0, bus.busy}, {31'h0, (vecs[k].len != 0)});
            if (vecs[k].len == 0) begin
                repeat (10) begin
                    check("zero_len_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
                    check("zero_len_valid", {31'h0, bus.data_valid}, 32'h0);
                    tick();
                end
            end
            wait_done();
            compare_words(vecs[k].addr, vecs[k].exp_words, vecs[k].exp_first);
            check("busy_end", {31'h0, bus.busy}, 32'h0);
        end

        // Burst with consumer backpressure: only FIFO_DEPTH reads may be issued
        clear_logs();
        bus.data_ready = 1'b0;
        send_cmd(24'h000100, 16'd8);
        repeat (40) tick();
        check("bp_req_count", req_addr.size(), 4);
        check("bp_valid", {31'h0, bus.data_valid}, 32'h1);
        check("bp_busy", {31'h0, bus.busy}, 32'h1);
        repeat (10) tick();
        check("bp_req_stalled", req_addr.size(), 4);
        check("bp_no_pop", pop_data.size(), 0);
        bus.data_ready = 1'b1;
        wait_done();
        compare_words(24'h000100, 8, 16'h0100);

        // Back-to-back commands
        clear_logs();
        send_cmd(24'h000020, 16'd2);
        send_cmd(24'h000040, 16'd2);
        check("b2b_busy", {31'h0, bus.busy}, 32'h1);
        check("b2b_cmd_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
        wait_done();
        check("b2b_count", pop_data.size(), 4);
        if (pop_data.size() == 4) begin
            check("b2b_w0", {15'h0, pop_data[0], pop_last[0]}, {15'h0, 16'h0020, 1'b0});
            check("b2b_w1", {15'h0, pop_data[1], pop_last[1]}, {15'h0, 16'h0021, 1'b1});
            check("b2b_w2", {15'h0, pop_data[2], pop_last[2]}, {15'h0, 16'h0040, 1'b0});
            check("b2b_w3", {15'h0, pop_data[3], pop_last[3]}, {15'h0, 16'h0041, 1'b1});
        end

        // Reset while the third read of five is in flight
        clear_logs();
        ack_lat = 6;
        send_cmd(24'h000300, 16'd5);
        begin
            bit seen = 0;
            for (int i = 0; i < 200; i++) begin
                if (req_addr.size() == 3) begin
                    seen = 1;
                    break;
                end
                tick();
            end
            check("rst_mid_third_req", {31'h0, seen}, 32'h1);
        end
        check("rst_mid_popped", pop_data.size(), 2);
        reset = 1'b1;
        tick();
        check("rst_mid_cmd_ready_low", {31'h0, bus.cmd_ready}, 32'h0);
        check("rst_mid_ram_req", {31'h0, bus.ram_req}, 32'h0);
        reset = 1'b0;
        tick();
        check("rst_mid_valid", {31'h0, bus.data_valid}, 32'h0);
        check("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_mid_cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
        repeat (15) tick();
        check("rst_mid_no_more_words", pop_data.size(), 2);
        check("rst_mid_no_more_reqs", req_addr.size(), 3);

        // Recovery after reset
        ack_lat = 2;
        clear_logs();
        send_cmd(24'h000600, 16'd1);
        wait_done();
        compare_words(24'h000600, 1, 16'h0600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
